// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner for the Pmod KYPD.
// Drives one column low at a time, debounces a single pressed row, emits a
// one-cycle key_valid per accepted press and shifts the key's hex code into
// a four-digit entry register. Release must also be stable before the next
// key can be accepted. STABLE_COUNT is expected to be at least 2.
module keypad_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int STABLE_COUNT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row,
    input  logic        clr,
    output logic [3:0]  col,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held,
    output logic [15:0] val
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(STABLE_COUNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(STABLE_COUNT);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    logic [3:0]       row_meta;
    logic [3:0]       rs;
    logic [DIV_W-1:0] div_cnt;
    logic             sample;

    state_t           state,   state_next;
    logic [1:0]       col_idx, col_idx_next;
    logic [CNT_W-1:0] cnt,     cnt_next;
    logic [3:0]       lat,     lat_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;
    logic             rs_one_low;
    logic [3:0]       new_code;

    // Row index of the single low bit in an active-low row pattern.
    function automatic logic [1:0] row_index(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        case (r)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Pmod KYPD legend for {row index, column index}.
    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        k = 4'h0;
        case ({r, c})
            4'b00_00: k = 4'h1;
            4'b01_00: k = 4'h4;
            4'b10_00: k = 4'h7;
            4'b11_00: k = 4'h0;
            4'b00_01: k = 4'h2;
            4'b01_01: k = 4'h5;
            4'b10_01: k = 4'h8;
            4'b11_01: k = 4'hF;
            4'b00_10: k = 4'h3;
            4'b01_10: k = 4'h6;
            4'b10_10: k = 4'h9;
            4'b11_10: k = 4'hE;
            4'b00_11: k = 4'hA;
            4'b01_11: k = 4'hB;
            4'b10_11: k = 4'hC;
            default:  k = 4'hD;
        endcase
        return k;
    endfunction

    // Two-flop synchronizer for the asynchronous row lines; idles at "no key".
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments let each flop capture its pre-edge
        // input; blocking ones would merge both stages into a single flop.
        if (!rst_n) begin
            row_meta <= 4'hF;
            rs       <= 4'hF;
        end else begin
            row_meta <= row;
            rs       <= row_meta;
        end
    end

    // Sample-period divider: counts 0..SCAN_DIV-1, sample point on the last count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (sample) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign sample     = (div_cnt == DIV_LAST);
    assign rs_one_low = ($countones(~rs) == 1);
    assign cnt_inc    = cnt + CNT_W'(1);
    assign new_code   = key_lookup(row_index(lat), col_idx);

    // FSM state register together with the column, stable count and latched row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= SCAN;
            col_idx <= 2'd0;
            cnt     <= '0;
            lat     <= 4'hF;
        end else begin
            state   <= state_next;
            col_idx <= col_idx_next;
            cnt     <= cnt_next;
            lat     <= lat_next;
        end
    end

    // Next-state logic: scanning, press debounce, hold, release debounce.
    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // no path leaves one unassigned, which would infer a latch.
        state_next   = state;
        col_idx_next = col_idx;
        cnt_next     = cnt;
        lat_next     = lat;
        accept       = 1'b0;
        case (state)
            SCAN: begin
                if (sample) begin
                    if (rs_one_low) begin
                        state_next = DEBOUNCE;
                        lat_next   = rs;
                        cnt_next   = CNT_W'(1);
                    end else begin
                        // Idle or ambiguous multi-row pattern: keep scanning.
                        col_idx_next = col_idx + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (sample) begin
                    if (rs == lat) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc >= CNT_DONE) begin
                            state_next = PRESSED;
                            accept     = 1'b1;
                        end
                    end else begin
                        state_next   = SCAN;
                        col_idx_next = col_idx + 2'd1;
                    end
                end
            end
            PRESSED: begin
                if (sample && rs == 4'hF) begin
                    state_next = RELEASE;
                    cnt_next   = CNT_W'(1);
                end
            end
            RELEASE: begin
                if (sample) begin
                    if (rs == 4'hF) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc >= CNT_DONE) begin
                            state_next   = SCAN;
                            col_idx_next = 2'd0;
                            cnt_next     = '0;
                        end
                    end else begin
                        state_next = PRESSED;
                    end
                end
            end
            default: begin
                state_next   = SCAN;
                col_idx_next = 2'd0;
                cnt_next     = '0;
            end
        endcase
    end

    // Moore outputs: active-low column drive and held indication.
    always_comb begin
        col      = ~(4'b0001 << col_idx);
        key_held = (state == PRESSED) || (state == RELEASE);
    end

    // Accept pulse, last key code and the shifting entry register with clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            val       <= 16'h0000;
        end else begin
            key_valid <= accept;
            if (accept) begin
                key_code <= new_code;
                val      <= clr ? {12'h000, new_code} : {val[11:0], new_code};
            end else if (clr) begin
                val <= 16'h0000;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan with a fast divider and short debounce. A keypad
// model turns the set of pressed keys into active-low row levels; expected
// accepts are queued when a press is issued and a monitor pops and compares
// them whenever key_valid pulses.
module tb_keypad_scan;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row;
    logic        clr;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [15:0] val;

    // pressed[r*4+c] is 1 while the key at row r, column c is held down.
    logic [15:0] pressed;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_checks;
    int n_fail;
    int n_valid;
    bit mon_en;

    keypad_scan #(
        .SCAN_DIV     (4),
        .STABLE_COUNT (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .clr       (clr),
        .col       (col),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held),
        .val       (val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a row reads low when a pressed key connects it to the
    // column currently driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row[r] = ~|(pressed[r*4 +: 4] & ~col);
        end
    end

    task automatic check(input string name, input logic [15:0] actual,
                         input logic [15:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: column drive sanity every cycle, scoreboard pop on key_valid.
    always @(negedge clk) begin
        if (mon_en) begin
            check("col_one_low", 16'($countones(~col)), 16'd1);
            if (key_valid) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected_valid: got key_valid with code %h val %h, expected none",
                             key_code, val);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_code", {12'h000, key_code}, {12'h000, mon_e.code});
                    check("sb_val", val, mon_e.val);
                end
            end
        end
    end

    task automatic wait_release(input string name);
        for (int i = 0; i < 200 && key_held !== 1'b0; i++) @(negedge clk);
        check({name, "_released"}, {15'd0, key_held}, 16'd0);
    endtask

    // Press a key, wait for its accept, and optionally release it again.
    task automatic press_key(input int r, input int c, input logic [3:0] code,
                             input logic [15:0] v, input bit release_after,
                             input string name);
        int start;
        start = n_valid;
        exp_q.push_back('{code, v});
        pressed[r*4+c] = 1'b1;
        for (int i = 0; i < 200 && n_valid == start; i++) @(negedge clk);
        check({name, "_accept_count"}, 16'(n_valid - start), 16'd1);
        check({name, "_held"}, {15'd0, key_held}, 16'd1);
        check({name, "_code"}, {12'h000, key_code}, {12'h000, code});
        check({name, "_val"}, val, v);
        if (release_after) begin
            repeat (12) @(negedge clk);
            check({name, "_still_held"}, {15'd0, key_held}, 16'd1);
            pressed[r*4+c] = 1'b0;
            wait_release(name);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int changes;
        logic [3:0] prev_col;

        n_checks = 0;
        n_fail   = 0;
        n_valid  = 0;
        mon_en   = 1'b0;
        pressed  = 16'h0000;
        clr      = 1'b0;
        rst_n    = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_col", {12'h000, col}, 16'h000E);
        check("rst_valid", {15'd0, key_valid}, 16'd0);
        check("rst_code", {12'h000, key_code}, 16'h0000);
        check("rst_held", {15'd0, key_held}, 16'd0);
        check("rst_val", val, 16'h0000);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (4) @(negedge clk);

        // Key "5": row 1, column 1.
        press_key(1, 1, 4'h5, 16'h0005, 1'b1, "key5");

        // Entry sequence 1,2,3,4,A shifting the 5 out.
        press_key(0, 0, 4'h1, 16'h0051, 1'b1, "key1");
        press_key(0, 1, 4'h2, 16'h0512, 1'b1, "key2");
        press_key(0, 2, 4'h3, 16'h5123, 1'b1, "key3");
        press_key(1, 0, 4'h4, 16'h1234, 1'b1, "key4");
        press_key(0, 3, 4'hA, 16'h234A, 1'b1, "keyA");
        check("seq_val", val, 16'h234A);

        // Bounce on key "6": 4 cycles on / 4 off, so samples alternate.
        start = n_valid;
        for (int k = 0; k < 12; k++) begin
            pressed[6] = 1'b1;
            repeat (4) @(negedge clk);
            pressed[6] = 1'b0;
            repeat (4) @(negedge clk);
        end
        check("bounce_no_valid", 16'(n_valid - start), 16'd0);
        check("bounce_val", val, 16'h234A);
        press_key(1, 2, 4'h6, 16'h34A6, 1'b1, "key6");

        // Key "7" with clr in its accept cycle. The release above just
        // returned the scanner to column 0 with the divider at 0, so the
        // accept edge is the 12th rising edge from here.
        start = n_valid;
        exp_q.push_back('{4'h7, 16'h0007});
        pressed[8] = 1'b1;
        repeat (11) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (2) @(negedge clk);
        check("clr_accept_count", 16'(n_valid - start), 16'd1);
        check("clr_accept_val", val, 16'h0007);
        pressed[8] = 1'b0;
        wait_release("key7");

        // clr on its own.
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_only_val", val, 16'h0000);

        // Two rows low in column 0: ambiguous, scanning must continue.
        start    = n_valid;
        changes  = 0;
        pressed  = 16'h0011;
        prev_col = col;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (col !== prev_col) changes++;
            prev_col = col;
        end
        check("two_row_col_rotates", {15'd0, changes >= 8}, 16'd1);
        check("two_row_no_valid", 16'(n_valid - start), 16'd0);
        check("two_row_not_held", {15'd0, key_held}, 16'd0);
        pressed = 16'h0000;
        repeat (10) @(negedge clk);

        // Reset while key "9" is held, then re-detection after reset.
        press_key(2, 2, 4'h9, 16'h0009, 1'b0, "key9");
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_col", {12'h000, col}, 16'h000E);
        check("rst_mid_valid", {15'd0, key_valid}, 16'd0);
        check("rst_mid_code", {12'h000, key_code}, 16'h0000);
        check("rst_mid_held", {15'd0, key_held}, 16'd0);
        check("rst_mid_val", val, 16'h0000);
        start = n_valid;
        exp_q.push_back('{4'h9, 16'h0009});
        rst_n = 1'b1;
        for (int i = 0; i < 200 && n_valid == start; i++) @(negedge clk);
        check("redetect_count", 16'(n_valid - start), 16'd1);
        check("redetect_held", {15'd0, key_held}, 16'd1);
        repeat (40) @(negedge clk);
        check("redetect_single", 16'(n_valid - start), 16'd1);
        pressed = 16'h0000;
        wait_release("key9_after_rst");

        repeat (5) @(negedge clk);
        check("sb_queue_empty", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000: clock cycles per column dwell and per debounce sample period.
REQ-002 The block SHALL have parameter STABLE_COUNT, default 8: consecutive identical samples required to accept a press or a release.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-005 The block SHALL have port row, input, 4 bits: keypad row lines, active-low, pulled up externally, asynchronous to clk.
REQ-006 The block SHALL have port clr, input, 1 bit: synchronous active-high clear of val.
REQ-007 The block SHALL have port col, output, 4 bits: column drive, active-low, exactly one bit low at all times.
REQ-008 The block SHALL have port key_valid, output, 1 bit: one-cycle pulse per accepted key press.
REQ-009 The block SHALL have port key_code, output, 4 bits: hex code of the last accepted key.
REQ-010 The block SHALL have port key_held, output, 1 bit: high while an accepted key has not yet been released.
REQ-011 The block SHALL have port val, output, 16 bits: four-digit hex entry register, most recent digit in val[3:0], ready for the four-digit hex display.

Function
REQ-012 row SHALL pass through a 2-flop synchronizer reset to 4'hF; all decisions use the synchronized value (rs).
REQ-013 A divider counter SHALL count 0..SCAN_DIV-1 and wrap; the sample point is the cycle where the counter equals SCAN_DIV-1.
REQ-014 FSM states SHALL be SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-015 In SCAN, col SHALL rotate 1110->1101->1011->0111->1110 at each sample point where rs==4'hF.
REQ-016 In SCAN, at a sample point with exactly one rs bit low, the FSM SHALL go to DEBOUNCE, holding col, latching rs, and setting the stable count to 1.
REQ-017 In SCAN, at a sample point with two or more rs bits low, the FSM SHALL treat it as no key and keep rotating col.
REQ-018 In DEBOUNCE, at each sample point, rs equal to the latched value SHALL increment the stable count; any other value SHALL return the FSM to SCAN with col advanced to the next column.
REQ-019 When the stable count reaches STABLE_COUNT, the FSM SHALL enter PRESSED and, in the same cycle, pulse key_valid, update key_code and update val.
REQ-020 key_code SHALL be {row index, column index}, indices 0..3 with index 0 = bit 0 low, mapped through the fixed Pmod KYPD layout.
REQ-021 Column 0 (rows 0..3) SHALL map to 1,4,7,0; column 1 to 2,5,8,F; column 2 to 3,6,9,E; column 3 to A,B,C,D.
REQ-022 On accept, val SHALL become {val[11:0], key_code}; the oldest digit is discarded with no saturation.
REQ-023 In PRESSED, at each sample point, rs==4'hF SHALL move the FSM to RELEASE with the count set to 1; otherwise it stays in PRESSED.
REQ-024 In RELEASE, rs==4'hF at a sample point SHALL increment the count; any low bit SHALL return the FSM to PRESSED.
REQ-025 When the RELEASE count reaches STABLE_COUNT, the FSM SHALL return to SCAN with col=4'b1110.
REQ-026 key_held SHALL be high exactly in PRESSED and RELEASE.
REQ-027 A second key pressed while one is held SHALL be ignored; no key_valid is generated until full release.
REQ-028 clr SHALL set val to 16'h0000 on the next edge.
REQ-029 If clr and an accept occur in the same cycle, val SHALL become {12'h000, key_code}, and key_valid still pulses.
REQ-030 Accept latency SHALL be STABLE_COUNT-1 sample periods after the first detecting sample point, plus the 2-cycle synchronizer delay.

Reset
REQ-031 While rst_n=0 at a clock edge, the block SHALL set col=4'b1110, key_valid=0, key_code=4'h0, key_held=0, val=16'h0000, state SCAN, and clear all counters and the synchronizer (to 4'hF).
REQ-032 Reset SHALL take priority over clr and all FSM activity, including a reset asserted mid-DEBOUNCE or mid-PRESSED.
REQ-033 A key still held after reset SHALL be re-detected through the normal SCAN/DEBOUNCE path.

Verification
REQ-034 With SCAN_DIV=4 and STABLE_COUNT=3, a bench SHALL press key "5" (row bit 1 low whenever col=1101) and check one key_valid pulse, key_code=4'h5, val=16'h0005, and key_held=1 until release.
REQ-035 A bench SHALL enter keys 1,2,3,4,A in sequence with releases between them and check val=16'h234A after the last press.
REQ-036 A bench SHALL apply a bounce pattern (row toggling within 2 sample periods) and check no key_valid; then hold the key steady and check exactly one key_valid.
REQ-037 A bench SHALL press two rows low in the same column and check that col keeps rotating and no key_valid occurs.
REQ-038 A bench SHALL assert clr in the accept cycle of key "7" and check val=16'h0007; clr alone SHALL give val=16'h0000.
REQ-039 A bench SHALL assert rst_n=0 in PRESSED, then release rst_n with the key held, and check that reset values appear, followed by exactly one new key_valid after re-debounce.
